// File: rtl/bar_anim_pkg.sv
// Shared constants, FSM state type and bar geometry helper for the bar scheduler.
package bar_anim_pkg;

  localparam int STEP_DEF     = 4;
  localparam int BAR_SIZE_DEF = 20;
  localparam int BAR_GAP_DEF  = 8;
  localparam int Y_BASE_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // First row of bar i; bars are stacked with a fixed pitch of height plus gap.
  function automatic int bar_y1(input int i, input int y_base, input int bar_size,
                                input int bar_gap);
    return y_base + i * (bar_size + 1 + bar_gap);
  endfunction

endpackage

// File: rtl/bar_hit_check.sv
// Combinational test of whether pixel (x, y) lies inside one bar.
module bar_hit_check #(
  parameter int X_BITS   = 13,
  parameter int Y_BITS   = 13,
  parameter int BAR_SIZE = 20
) (
  input  logic [X_BITS-1:0] x,
  input  logic [Y_BITS-1:0] y,
  input  logic [X_BITS-1:0] cur_i,
  input  logic [Y_BITS-1:0] y1_i,
  output logic              hit_i
);

  localparam int YW = Y_BITS + 1;

  logic [Y_BITS:0] y_end;

  // Last row is computed one bit wider so a bar near the bottom cannot wrap.
  always_comb begin
    y_end = {1'b0, y1_i} + YW'(BAR_SIZE);
    hit_i = (x <= cur_i) && (y >= y1_i) && ({1'b0, y} <= y_end);
  end

endmodule

// File: rtl/bar_anim_scheduler.sv
// Per-frame bar length sequencer: one bar updated per clock after each vsync edge,
// plus a registered per-pixel hit output for the pattern generator.
//
// state  | meaning
// IDLE   | waiting for a vsync rising edge or a pending pass
// UPDATE | stepping bar idx toward its target or along its bounce path
// DONE   | pass finished; frame_done pulses for this one cycle
module bar_anim_scheduler
  import bar_anim_pkg::*;
#(
  parameter int NUM_BARS = 4,
  parameter int X_BITS   = 13,
  parameter int Y_BITS   = 13,
  parameter int STEP     = STEP_DEF,
  parameter int BAR_SIZE = BAR_SIZE_DEF,
  parameter int BAR_GAP  = BAR_GAP_DEF,
  parameter int Y_BASE   = Y_BASE_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       vsync,
  input  logic [X_BITS-1:0]          total_active_pix,
  input  logic [X_BITS-1:0]          x,
  input  logic [Y_BITS-1:0]          y,
  input  logic                       wr_en,
  input  logic [2:0]                 wr_idx,
  input  logic [X_BITS-1:0]          wr_value,
  input  logic [NUM_BARS-1:0]        bounce,
  output logic [NUM_BARS*X_BITS-1:0] bar_value,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       draw,
  output logic [2:0]                 draw_idx
);

  localparam logic [2:0]      LAST_IDX = 3'(NUM_BARS - 1);
  localparam logic [X_BITS:0] STEP_W   = STEP[X_BITS:0];

  state_t state, state_n;
  logic [2:0] idx, idx_n;
  logic pending, pending_n;
  logic vsync_d;
  logic start;

  logic [X_BITS-1:0] cur [NUM_BARS];
  logic [X_BITS-1:0] tgt [NUM_BARS];
  logic [NUM_BARS-1:0] dir;  // 0 = moving up, 1 = moving down

  logic [X_BITS-1:0] cur_sel, tgt_sel, clamped, cur_new, wr_clamped;
  logic              dir_sel, dir_new, bounce_sel;
  logic [X_BITS:0]   sum, lim_w;

  logic [NUM_BARS-1:0] hit;
  logic                hit_any;
  logic [2:0]          hit_idx;

  assign start      = vsync & ~vsync_d;
  assign busy       = (state == UPDATE);
  assign frame_done = (state == DONE);
  assign wr_clamped = (wr_value > total_active_pix) ? total_active_pix : wr_value;

  // FSM state, pass index, pending flag and vsync edge history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      pending <= 1'b0;
      vsync_d <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      pending <= pending_n;
      vsync_d <= vsync;
    end
  end

  // Next-state: an edge seen while a pass is running is remembered once.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    pending_n = pending;
    case (state)
      IDLE: begin
        if (start || pending) begin
          state_n   = UPDATE;
          idx_n     = '0;
          pending_n = 1'b0;
        end
      end
      UPDATE: begin
        if (start) pending_n = 1'b1;
        if (idx == LAST_IDX) state_n = DONE;
        else                 idx_n   = idx + 3'd1;
      end
      DONE: begin
        if (start) pending_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Select the registers of the bar currently being updated.
  always_comb begin
    cur_sel    = '0;
    tgt_sel    = '0;
    dir_sel    = 1'b0;
    bounce_sel = 1'b0;
    for (int i = 0; i < NUM_BARS; i++) begin
      if (idx == 3'(i)) begin
        cur_sel    = cur[i];
        tgt_sel    = tgt[i];
        dir_sel    = dir[i];
        bounce_sel = bounce[i];
      end
    end
  end

  // One step of the selected bar; cur is first pulled inside the active width.
  always_comb begin
    clamped = (cur_sel > total_active_pix) ? total_active_pix : cur_sel;
    sum     = {1'b0, clamped} + STEP_W;
    lim_w   = {1'b0, total_active_pix};
    cur_new = clamped;
    dir_new = dir_sel;
    if (bounce_sel) begin
      if (!dir_sel) begin
        if (sum >= lim_w) begin
          cur_new = total_active_pix;
          dir_new = 1'b1;
        end else begin
          cur_new = sum[X_BITS-1:0];
        end
      end else begin
        if ({1'b0, clamped} <= STEP_W) begin
          cur_new = '0;
          dir_new = 1'b0;
        end else begin
          cur_new = clamped - STEP_W[X_BITS-1:0];
        end
      end
    end else begin
      if (clamped < tgt_sel) begin
        cur_new = (sum >= {1'b0, tgt_sel}) ? tgt_sel : sum[X_BITS-1:0];
      end else if (clamped > tgt_sel) begin
        cur_new = ({1'b0, clamped} <= ({1'b0, tgt_sel} + STEP_W)) ?
                  tgt_sel : clamped - STEP_W[X_BITS-1:0];
      end
    end
  end

  // Bar registers: target writes at any time, cur/dir only for the bar in the pass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BARS; i++) begin
        cur[i] <= '0;
        tgt[i] <= '0;
      end
      dir <= '0;
    end else begin
      for (int i = 0; i < NUM_BARS; i++) begin
        if (wr_en && (wr_idx == 3'(i))) tgt[i] <= wr_clamped;
        if ((state == UPDATE) && (idx == 3'(i))) begin
          cur[i] <= cur_new;
          dir[i] <= dir_new;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_BARS; g++) begin : g_bar
    localparam logic [Y_BITS-1:0] Y1 = Y_BITS'(bar_y1(g, Y_BASE, BAR_SIZE, BAR_GAP));

    assign bar_value[g*X_BITS +: X_BITS] = cur[g];

    bar_hit_check #(
      .X_BITS  (X_BITS),
      .Y_BITS  (Y_BITS),
      .BAR_SIZE(BAR_SIZE)
    ) u_hit (
      .x    (x),
      .y    (y),
      .cur_i(cur[g]),
      .y1_i (Y1),
      .hit_i(hit[g])
    );
  end

  // Lowest-index hit wins; scanning downward leaves the lowest index last.
  always_comb begin
    hit_any = |hit;
    hit_idx = '0;
    for (int i = NUM_BARS - 1; i >= 0; i--) begin
      if (hit[i]) hit_idx = 3'(i);
    end
  end

  // Draw outputs lag x/y by one clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      draw     <= 1'b0;
      draw_idx <= '0;
    end else begin
      draw     <= hit_any;
      draw_idx <= hit_idx;
    end
  end

endmodule
